// File: rtl/race_pkg.sv
// Shared types and constants for the LED race round controller and lane logic.
package race_pkg;

    // Round/match FSM states; the encoding is shown on the board display.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRace    = 3'd1,
        StMotoFin = 3'd2,
        StCarFin  = 3'd4,
        StWin     = 3'd5
    } race_state_e;

    // Match winner codes.
    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinCar  = 2'b01;
    localparam logic [1:0] WinMoto = 2'b10;

    // Highest score a lane can hold; a round won at this score ends the match.
    localparam logic [1:0] PointMax = 2'd3;

    // Lane start/goal patterns used by the lane shifters.
    localparam int unsigned LaneWidth = 8;
    localparam logic [LaneWidth-1:0] CarStart  = 8'b0000_0001;
    localparam logic [LaneWidth-1:0] CarGoal   = 8'b1000_0000;
    localparam logic [LaneWidth-1:0] MotoStart = 8'b1000_0000;
    localparam logic [LaneWidth-1:0] MotoGoal  = 8'b0000_0001;

endpackage

// File: rtl/race_tick_gen.sv
// Free-running prescaler producing slow and fast tick conditions from one counter.
module race_tick_gen #(
    parameter int unsigned SLOW_DIV = 2**27,
    parameter int unsigned FAST_DIV = 2**24
) (
    input  logic clk,
    input  logic rst,
    output logic slow_tick,
    output logic fast_tick
);

    localparam int unsigned CntW  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam int unsigned FastW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(SLOW_DIV - 1);

    logic [CntW-1:0] cnt_q;

    // Counter wraps at SLOW_DIV; only reset touches it, never the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_q == TermCnt) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign slow_tick = (cnt_q == TermCnt);
    // FAST_DIV is a power of two dividing SLOW_DIV, so the low bits recur evenly.
    assign fast_tick = (FAST_DIV == 1) ? 1'b1 : (&cnt_q[FastW-1:0]);

endmodule

// File: rtl/race_scheduler.sv
// Round controller: step enables for both lanes, boost budget, scores and match FSM.
module race_scheduler
    import race_pkg::*;
#(
    parameter int unsigned SLOW_DIV    = 2**27,
    parameter int unsigned FAST_DIV    = 2**24,
    parameter int unsigned BOOST_STEPS = 4,
    parameter int unsigned HOLD_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       speed,
    input  logic       freeze,
    input  logic       car_at_goal,
    input  logic       moto_at_goal,
    output logic       car_step,
    output logic       moto_step,
    output logic       lane_reload,
    output logic [1:0] car_point,
    output logic [1:0] moto_point,
    output logic [2:0] state,
    output logic [1:0] winner
);

    localparam int unsigned BoostW = (BOOST_STEPS > 0) ? $clog2(BOOST_STEPS + 1) : 1;
    localparam int unsigned HoldW  = $clog2(HOLD_TICKS + 1);
    localparam logic [BoostW-1:0] BoostMax = BoostW'(BOOST_STEPS);
    localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_TICKS - 1);

    logic slow_tick;
    logic fast_tick;

    race_tick_gen #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .slow_tick (slow_tick),
        .fast_tick (fast_tick)
    );

    race_state_e       state_q, state_d;
    logic [1:0]        car_pt_q, car_pt_d;
    logic [1:0]        moto_pt_q, moto_pt_d;
    logic [1:0]        winner_q, winner_d;
    logic [BoostW-1:0] boost_cnt_q, boost_cnt_d;
    logic              boost_spent_q, boost_spent_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              car_step_q, car_step_d;
    logic              moto_step_q, moto_step_d;
    logic              reload_q, reload_d;
    logic              speed_q;
    logic              boost_active;

    assign boost_active = speed & ~boost_spent_q & (boost_cnt_q < BoostMax);

    // State, score, budget and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            car_pt_q      <= '0;
            moto_pt_q     <= '0;
            winner_q      <= WinNone;
            boost_cnt_q   <= '0;
            boost_spent_q <= 1'b0;
            hold_q        <= '0;
            car_step_q    <= 1'b0;
            moto_step_q   <= 1'b0;
            reload_q      <= 1'b0;
            speed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            car_pt_q      <= car_pt_d;
            moto_pt_q     <= moto_pt_d;
            winner_q      <= winner_d;
            boost_cnt_q   <= boost_cnt_d;
            boost_spent_q <= boost_spent_d;
            hold_q        <= hold_d;
            car_step_q    <= car_step_d;
            moto_step_q   <= moto_step_d;
            reload_q      <= reload_d;
            speed_q       <= speed;
        end
    end

    // Next-state, scoring, boost accounting and pulse decisions.
    always_comb begin
        state_d       = state_q;
        car_pt_d      = car_pt_q;
        moto_pt_d     = moto_pt_q;
        winner_d      = winner_q;
        boost_cnt_d   = boost_cnt_q;
        boost_spent_d = boost_spent_q;
        hold_d        = hold_q;
        car_step_d    = 1'b0;
        moto_step_d   = 1'b0;
        reload_d      = 1'b0;

        case (state_q)
            StIdle: begin
                // A new match starts with a clean score and a fresh boost budget.
                car_pt_d      = '0;
                moto_pt_d     = '0;
                winner_d      = WinNone;
                boost_cnt_d   = '0;
                boost_spent_d = 1'b0;
                if (en) begin
                    state_d = StRace;
                    hold_d  = '0;
                end
            end
            StRace: begin
                // Releasing boost after using some of it forfeits the rest of the round's budget.
                if (speed_q && !speed && (boost_cnt_q != '0)) begin
                    boost_spent_d = 1'b1;
                end
                if (moto_at_goal) begin
                    hold_d = '0;
                    if (moto_pt_q == PointMax) begin
                        state_d  = StWin;
                        winner_d = WinMoto;
                    end else begin
                        moto_pt_d = moto_pt_q + 2'd1;
                        state_d   = StMotoFin;
                    end
                end else if (car_at_goal) begin
                    hold_d = '0;
                    if (car_pt_q == PointMax) begin
                        state_d  = StWin;
                        winner_d = WinCar;
                    end else begin
                        car_pt_d = car_pt_q + 2'd1;
                        state_d  = StCarFin;
                    end
                end else if (en) begin
                    moto_step_d = ~freeze & slow_tick;
                    car_step_d  = boost_active ? fast_tick : slow_tick;
                    if (car_step_d && boost_active) begin
                        boost_cnt_d = boost_cnt_q + BoostW'(1);
                    end
                end
            end
            StMotoFin, StCarFin: begin
                if (slow_tick) begin
                    if (hold_q == HoldLast) begin
                        hold_d        = '0;
                        reload_d      = 1'b1;
                        boost_cnt_d   = '0;
                        boost_spent_d = 1'b0;
                        state_d       = StRace;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            StWin: begin
                if (slow_tick) begin
                    if (hold_q == HoldLast) begin
                        hold_d    = '0;
                        reload_d  = 1'b1;
                        car_pt_d  = '0;
                        moto_pt_d = '0;
                        winner_d  = WinNone;
                        state_d   = StIdle;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign car_step    = car_step_q;
    assign moto_step   = moto_step_q;
    assign lane_reload = reload_q;
    assign car_point   = car_pt_q;
    assign moto_point  = moto_pt_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_race_scheduler.sv
// Self-checking bench for race_scheduler: directed scenarios plus random play,
// every cycle compared against a round-level reference model.
module tb_race_scheduler;
    import race_pkg::*;

    localparam int SlowDiv    = 16;
    localparam int FastDiv    = 2;
    localparam int BoostSteps = 4;
    localparam int HoldTicks  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       speed = 1'b0;
    logic       freeze = 1'b0;
    logic       car_at_goal = 1'b0;
    logic       moto_at_goal = 1'b0;
    logic       car_step;
    logic       moto_step;
    logic       lane_reload;
    logic [1:0] car_point;
    logic [1:0] moto_point;
    logic [2:0] state;
    logic [1:0] winner;

    race_scheduler #(
        .SLOW_DIV    (SlowDiv),
        .FAST_DIV    (FastDiv),
        .BOOST_STEPS (BoostSteps),
        .HOLD_TICKS  (HoldTicks)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .speed        (speed),
        .freeze       (freeze),
        .car_at_goal  (car_at_goal),
        .moto_at_goal (moto_at_goal),
        .car_step     (car_step),
        .moto_step    (moto_step),
        .lane_reload  (lane_reload),
        .car_point    (car_point),
        .moto_point   (moto_point),
        .state        (state),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: elapsed edges since reset give prescaler phase directly.
    int         m_edges;
    logic [2:0] m_state;
    logic [1:0] m_cp, m_mp, m_win;
    int         m_used, m_hold;
    bit         m_locked, m_prev_speed;
    bit         e_car, e_moto, e_reload;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {state, car_step, moto_step, lane_reload, car_point, moto_point, winner};
    endfunction

    function automatic logic [11:0] model_vec();
        return {m_state, e_car, e_moto, e_reload, m_cp, m_mp, m_win};
    endfunction

    task automatic model_reset();
        m_edges = 0; m_state = StIdle; m_cp = 0; m_mp = 0; m_win = 0;
        m_used = 0; m_hold = 0; m_locked = 0; m_prev_speed = 0;
        e_car = 0; e_moto = 0; e_reload = 0;
    endtask

    task automatic model_edge();
        int pre;
        bit slow, fast, boosting;
        pre = m_edges % SlowDiv;
        slow = (pre == SlowDiv - 1);
        fast = ((pre % FastDiv) == FastDiv - 1);
        m_edges++;
        e_car = 0; e_moto = 0; e_reload = 0;
        boosting = speed && !m_locked && (m_used < BoostSteps);
        case (m_state)
            StIdle: begin
                m_used = 0; m_locked = 0;
                if (en) begin m_state = StRace; m_hold = 0; end
            end
            StRace: begin
                if (m_prev_speed && !speed && m_used > 0) m_locked = 1;
                if (moto_at_goal) begin
                    m_hold = 0;
                    if (m_mp == 3) begin m_state = StWin; m_win = WinMoto; end
                    else begin m_mp++; m_state = StMotoFin; end
                end else if (car_at_goal) begin
                    m_hold = 0;
                    if (m_cp == 3) begin m_state = StWin; m_win = WinCar; end
                    else begin m_cp++; m_state = StCarFin; end
                end else if (en) begin
                    e_moto = !freeze && slow;
                    if (boosting ? fast : slow) begin
                        e_car = 1;
                        if (boosting) m_used++;
                    end
                end
            end
            StMotoFin, StCarFin, StWin: begin
                if (slow) begin
                    m_hold++;
                    if (m_hold == HoldTicks) begin
                        m_hold = 0; e_reload = 1;
                        if (m_state == StWin) begin
                            m_cp = 0; m_mp = 0; m_win = 0; m_state = StIdle;
                        end else begin
                            m_used = 0; m_locked = 0; m_state = StRace;
                        end
                    end
                end
            end
            default: m_state = StIdle;
        endcase
        m_prev_speed = speed;
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic count_steps(input int n, output int cs, output int ms);
        cs = 0; ms = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (car_step) cs++;
            if (moto_step) ms++;
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag,
                              output int reloads);
        reloads = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (lane_reload) reloads++;
            if (state == target) return;
        end
        check({"wait_", tag}, 32'(state), 32'(target));
    endtask

    task automatic goal_round(input bit car, input bit moto);
        int rl;
        car_at_goal = car; moto_at_goal = moto;
        tick();
        car_at_goal = 0; moto_at_goal = 0;
        wait_state(StRace, 64, "round", rl);
        check("round_reload", rl, 1);
    endtask

    initial begin
        int cs, ms, rl, last, gap_bad;
        bit found;
        model_reset();

        // Asynchronous reset with no clock edge involved.
        #2 rst = 1'b0;
        #1 check("reset_async", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("reset_state", 32'(dut_vec()), 32'h0);

        // Match start and normal lane speed.
        en = 1'b1;
        tick();
        check("race_after_en", 32'(state), 32'(StRace));
        count_steps(32, cs, ms);
        check("slow_car_steps", cs, 2);
        check("slow_moto_steps", ms, 2);

        // Full boost budget, then slow again; re-raising gives nothing more.
        speed = 1'b1;
        last = -1; gap_bad = 0; cs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (car_step) begin
                if (last >= 0 && i - last != 2) gap_bad++;
                last = i; cs++;
            end
        end
        check("boost_steps", cs, 4);
        check("boost_gap", gap_bad, 0);
        count_steps(32, cs, ms);
        check("post_boost_steps", cs, 2);
        speed = 1'b0;
        count_steps(4, cs, ms);
        speed = 1'b1;
        count_steps(32, cs, ms);
        check("no_reboost", cs, 2);
        speed = 1'b0;

        // Frozen motorcycle.
        freeze = 1'b1;
        count_steps(64, cs, ms);
        check("freeze_moto", ms, 0);
        check("freeze_car", cs, 4);
        freeze = 1'b0;

        // Motorcycle rounds: 0 -> 1, then 1 -> 2 through MOTO_FIN.
        goal_round(1'b0, 1'b1);
        check("moto_pt_1", 32'(moto_point), 1);
        moto_at_goal = 1'b1;
        tick();
        moto_at_goal = 1'b0;
        check("moto_fin_state", 32'(state), 32'(StMotoFin));
        check("moto_pt_2", 32'(moto_point), 2);
        wait_state(StRace, 64, "moto_fin", rl);
        check("moto_fin_reload", rl, 1);

        // Fresh round budget; partial boost then release locks it out.
        speed = 1'b1;
        count_steps(4, cs, ms);
        check("partial_boost", cs, 2);
        speed = 1'b0;
        count_steps(2, cs, ms);
        speed = 1'b1;
        count_steps(32, cs, ms);
        check("boost_locked", cs, 2);
        speed = 1'b0;

        // Both to 3, then a simultaneous finish goes to the motorcycle.
        goal_round(1'b1, 1'b0);
        goal_round(1'b1, 1'b0);
        goal_round(1'b1, 1'b0);
        goal_round(1'b0, 1'b1);
        check("car_pt_3", 32'(car_point), 3);
        check("moto_pt_3", 32'(moto_point), 3);
        car_at_goal = 1'b1; moto_at_goal = 1'b1;
        tick();
        car_at_goal = 1'b0; moto_at_goal = 1'b0;
        check("win_state", 32'(state), 32'(StWin));
        check("win_code", 32'(winner), 32'(WinMoto));
        wait_state(StIdle, 64, "win", rl);
        check("win_reload", rl, 1);
        check("idle_car_pt", 32'(car_point), 0);
        check("idle_moto_pt", 32'(moto_point), 0);
        check("idle_winner", 32'(winner), 0);

        // Random play against the model.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom % 8) != 0;
            if ($urandom % 8 == 0) speed = ~speed;
            freeze = ($urandom % 4) == 0;
            car_at_goal = ($urandom % 40) == 0;
            moto_at_goal = ($urandom % 40) == 0;
            tick();
        end

        // Reset in the middle of a race while a step pulse is high.
        en = 1'b1; speed = 1'b0; freeze = 1'b0; car_at_goal = 1'b0; moto_at_goal = 1'b0;
        wait_state(StRace, 100, "pre_reset", rl);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (car_step) found = 1;
        end
        check("pre_reset_step", 32'(found), 1);
        #2 rst = 1'b0;
        #1 check("reset_mid", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
